// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared SPI master types: FSM states, SPI mode encodings, default width.
// Revision : 1.0
// ============================================================================
package spi_pkg;

  localparam int c_DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_TRANSFER = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  // {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_if
// Purpose  : Host handshake and SPI pin bundle for spi_master.
// Revision : 1.0
// ============================================================================
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int DATA_W = c_DEFAULT_DATA_W
);

  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              SCLK;
  logic              CS;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  start, mode, tx_data, MISO,
    output rx_data, busy, done, SCLK, CS, MOSI
  );

  modport slave (
    output start, mode, tx_data, MISO,
    input  rx_data, busy, done, SCLK, CS, MOSI
  );

endinterface
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_gen
// Purpose  : SCLK half-period divider with leading/trailing edge strobes.
// Revision : 1.0
// ============================================================================
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_cpol,
  output logic o_lead_edge,
  output logic o_trail_edge,
  output logic o_sclk
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  logic [c_DIV_W-1:0] r_div;
  logic               r_sclk;
  logic               w_tick;

  // Strobes mark the last cycle of a half period; SCLK flips on the following edge.
  assign w_tick       = i_en && (r_div == c_DIV_LAST);
  assign o_lead_edge  = w_tick && (r_sclk == i_cpol);
  assign o_trail_edge = w_tick && (r_sclk != i_cpol);
  assign o_sclk       = r_sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_div  <= '0;
      r_sclk <= i_cpol;
    end else if (w_tick) begin
      r_div  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : SPI master frame engine (IDLE/SETUP/TRANSFER/HOLD), all four modes.
//            Build option SPI_MASTER_MSB_FIRST_EN shifts MSB first (default LSB first).
// Revision : 1.0
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = c_DEFAULT_DATA_W,
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  localparam int                  c_EDGE_W     = $clog2(2 * DATA_W + 1);
  localparam logic [7:0]          c_PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [c_EDGE_W-1:0] c_EDGE_LAST  = c_EDGE_W'(2 * DATA_W - 1);

  state_t              r_state;
  spi_mode_t           r_mode;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_cs;
  logic                r_busy;
  logic                r_done;
  logic [7:0]          r_cnt;
  logic [c_EDGE_W-1:0] r_edge;

  logic              w_en;
  logic              w_cpol;
  logic              w_lead;
  logic              w_trail;
  logic              w_sclk;
  logic              w_sample;
  logic              w_shift;
  logic              w_mosi;
  logic [DATA_W-1:0] w_tx_shifted;
  logic [DATA_W-1:0] w_rx_shifted;

  assign w_en   = (r_state == ST_TRANSFER);
  // Feed the incoming CPOL on the accepting edge so SCLK settles as SETUP begins.
  assign w_cpol = ((r_state == ST_IDLE) && bus.start) ? bus.mode[1] : r_mode[1];

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_en),
    .i_cpol       (w_cpol),
    .o_lead_edge  (w_lead),
    .o_trail_edge (w_trail),
    .o_sclk       (w_sclk)
  );

  // CPHA=1 keeps the SETUP bit through the first leading edge; CPHA=0 skips the shift after the final edge.
  assign w_sample = r_mode[0] ? w_trail : w_lead;
  assign w_shift  = r_mode[0] ? (w_lead && (r_edge != '0))
                              : (w_trail && (r_edge != c_EDGE_LAST));

`ifdef SPI_MASTER_MSB_FIRST_EN
  assign w_mosi       = r_tx[DATA_W-1];
  assign w_tx_shifted = {r_tx[DATA_W-2:0], 1'b0};
  assign w_rx_shifted = {r_rx[DATA_W-2:0], bus.MISO};
`else
  assign w_mosi       = r_tx[0];
  assign w_tx_shifted = {1'b0, r_tx[DATA_W-1:1]};
  assign w_rx_shifted = {bus.MISO, r_rx[DATA_W-1:1]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_edge    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_SETUP;
            r_mode  <= spi_mode_t'(bus.mode);
            r_tx    <= bus.tx_data;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_edge  <= '0;
          end
        end
        ST_SETUP: begin
          if (r_cnt == c_PHASE_LAST) begin
            r_state <= ST_TRANSFER;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_TRANSFER: begin
          if (w_lead || w_trail) r_edge <= r_edge + 1'b1;
          if (w_sample) r_rx <= w_rx_shifted;
          if (w_shift) r_tx <= w_tx_shifted;
          if (w_trail && (r_edge == c_EDGE_LAST)) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_cnt == c_PHASE_LAST) begin
            r_state   <= ST_IDLE;
            r_cs      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
            r_tx      <= '0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.SCLK    = w_sclk;
  assign bus.CS      = r_cs;
  assign bus.MOSI    = w_mosi;

endmodule
`default_nettype wire
